// File: rtl/gc_refresh_pkg.sv
// Shared types and sizing helpers for the gain-cell refresh sequencer.
package gc_refresh_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_HOST,
        READ,
        WAIT_DATA,
        WRITE,
        NEXT,
        DONE
    } refresh_state_t;

    localparam int DEFAULT_NUM_ROWS = 32;
    localparam int DEFAULT_DATA_W   = 32;
    localparam int DEFAULT_READ_LAT = 1;

    // Row address width; a single-row array would still need one bit.
    function automatic int row_width(input int num_rows);
        return (num_rows > 1) ? $clog2(num_rows) : 1;
    endfunction

    // Width of the read-latency counter, which counts 0..read_lat-1.
    function automatic int wait_width(input int read_lat);
        return (read_lat > 1) ? $clog2(read_lat) : 1;
    endfunction

    // Cycles from the first READ to the DONE cycle inclusive. The interval
    // counter period must exceed this plus the longest host_busy stretch.
    function automatic int pass_cycles(input int num_rows, input int read_lat);
        return num_rows * (read_lat + 3) + 1;
    endfunction

endpackage

// File: rtl/refresh_sequencer_if.sv
// Request/array bus between the refresh sequencer and its surroundings
// (interval counter, host arbitration and the array access mux).
interface refresh_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int ROW_W  = 5
);

    logic              refresh_req;
    logic              host_busy;
    logic              cycle_done;
    logic              refresh_active;
    logic [ROW_W-1:0]  arr_row;
    logic              arr_rd_en;
    logic              arr_wr_en;
    logic [DATA_W-1:0] arr_wr_data;
    logic [DATA_W-1:0] arr_rd_data;

    // The sequencer side: drives the array strobes and the status outputs.
    modport master (
        input  refresh_req,
        input  host_busy,
        input  arr_rd_data,
        output cycle_done,
        output refresh_active,
        output arr_row,
        output arr_rd_en,
        output arr_wr_en,
        output arr_wr_data
    );

    // The environment side: counter, host tracker and array.
    modport slave (
        output refresh_req,
        output host_busy,
        output arr_rd_data,
        input  cycle_done,
        input  refresh_active,
        input  arr_row,
        input  arr_rd_en,
        input  arr_wr_en,
        input  arr_wr_data
    );

endinterface

// File: rtl/refresh_sequencer.sv
// Refresh sequencer: on a refresh request, waits for the host to drain, then
// reads and writes back every row of the gain-cell array once and pulses
// cycle_done so the interval counter drops its request.
module refresh_sequencer
    import gc_refresh_pkg::*;
#(
    parameter int NUM_ROWS = DEFAULT_NUM_ROWS,
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int READ_LAT = DEFAULT_READ_LAT
) (
    input  logic                clk,
    input  logic                rst,
    refresh_sequencer_if.master bus
);

    localparam int ROW_W  = row_width(NUM_ROWS);
    localparam int WAIT_W = wait_width(READ_LAT);

    // Wrap explicitly at NUM_ROWS-1 so non-power-of-2 arrays never address
    // a row that does not exist.
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(NUM_ROWS - 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(READ_LAT - 1);

    refresh_state_t    state;
    logic [ROW_W-1:0]  row_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [DATA_W-1:0] data_reg;

    // The captured read data is itself a register, so it doubles as the
    // write-back bus without a second copy.
    assign bus.arr_wr_data = data_reg;

    // Single FSM; every output is registered alongside the state it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            row_cnt            <= '0;
            wait_cnt           <= '0;
            data_reg           <= '0;
            bus.cycle_done     <= 1'b0;
            bus.refresh_active <= 1'b0;
            bus.arr_row        <= '0;
            bus.arr_rd_en      <= 1'b0;
            bus.arr_wr_en      <= 1'b0;
        end else begin
            bus.arr_rd_en  <= 1'b0;
            bus.arr_wr_en  <= 1'b0;
            bus.cycle_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.refresh_req) begin
                        bus.refresh_active <= 1'b1;
                        bus.arr_row        <= row_cnt;
                        if (bus.host_busy) begin
                            state <= WAIT_HOST;
                        end else begin
                            state         <= READ;
                            bus.arr_rd_en <= 1'b1;
                        end
                    end
                end
                WAIT_HOST: begin
                    if (!bus.host_busy) begin
                        state         <= READ;
                        bus.arr_rd_en <= 1'b1;
                    end
                end
                READ: begin
                    state    <= WAIT_DATA;
                    wait_cnt <= '0;
                end
                WAIT_DATA: begin
                    if (wait_cnt == LAST_WAIT) begin
                        data_reg      <= bus.arr_rd_data;
                        state         <= WRITE;
                        bus.arr_wr_en <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                WRITE: begin
                    state <= NEXT;
                end
                NEXT: begin
                    if (row_cnt == LAST_ROW) begin
                        row_cnt        <= '0;
                        bus.arr_row    <= '0;
                        state          <= DONE;
                        bus.cycle_done <= 1'b1;
                    end else begin
                        row_cnt       <= row_cnt + ROW_W'(1);
                        bus.arr_row   <= row_cnt + ROW_W'(1);
                        state         <= READ;
                        bus.arr_rd_en <= 1'b1;
                    end
                end
                DONE: begin
                    state              <= IDLE;
                    bus.refresh_active <= 1'b0;
                    bus.arr_row        <= '0;
                end
                default: begin
                    state              <= IDLE;
                    row_cnt            <= '0;
                    bus.refresh_active <= 1'b0;
                    bus.arr_row        <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_refresh_sequencer.sv
// Testbench for refresh_sequencer: two instances (4 rows / latency 1 and
// 3 rows / latency 3), small array models, and a write-back scoreboard.
module tb_refresh_sequencer;
    import gc_refresh_pkg::*;

    localparam int ROWS_A = 4;
    localparam int LAT_A  = 1;
    localparam int ROWS_B = 3;
    localparam int LAT_B  = 3;
    localparam int DW     = 32;
    // Pass lengths, first READ to DONE inclusive: rows*(lat+3)+1.
    localparam int PASS_A = 17;
    localparam int PASS_B = 19;
    localparam logic [31:0] POISON = 32'hDEAD_BEEF;

    typedef struct packed {
        logic [1:0]  row;
        logic [31:0] data;
        int          rd_cyc;
    } sb_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    refresh_sequencer_if #(.DATA_W(DW), .ROW_W(2)) bus_a ();
    refresh_sequencer_if #(.DATA_W(DW), .ROW_W(2)) bus_b ();

    refresh_sequencer #(.NUM_ROWS(ROWS_A), .DATA_W(DW), .READ_LAT(LAT_A)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    refresh_sequencer #(.NUM_ROWS(ROWS_B), .DATA_W(DW), .READ_LAT(LAT_B)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Array models: read data is valid only in the cycle READ_LAT after the
    // strobe, poison otherwise, so a mistimed capture shows up as bad data.
    logic [31:0] mem_a [4];
    logic [31:0] mem_b [4];
    logic        va = 1'b0;
    logic [31:0] da;
    logic [2:0]  vb = 3'b000;
    logic [31:0] db [3];

    always @(posedge clk) begin
        va <= bus_a.arr_rd_en;
        da <= mem_a[bus_a.arr_row];
        vb <= {vb[1:0], bus_b.arr_rd_en};
        db[0] <= mem_b[bus_b.arr_row];
        db[1] <= db[0];
        db[2] <= db[1];
    end

    assign bus_a.arr_rd_data = va ? da : POISON;
    assign bus_b.arr_rd_data = vb[2] ? db[2] : POISON;

    // Scoreboard state per instance.
    sb_t q_a [$];
    sb_t q_b [$];
    int  cyc = 0;
    int  exp_row_a = 0, act_a = 0, last_act_a = 0, first_rd_a = -1, done_a = 0, wr_a = 0;
    int  exp_row_b = 0, first_rd_b = -1, done_b = 0, wr_b = 0;

    // Monitor A: push expected write-back on each read, pop on each write.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                q_a.delete();
                exp_row_a  = 0;
                act_a      = 0;
                first_rd_a = -1;
            end else begin
                if (bus_a.refresh_active) act_a++;
                if (bus_a.arr_rd_en) begin
                    checkOutput("a_rd_row", 64'(bus_a.arr_row), 64'(exp_row_a));
                    checkOutput("a_rd_wr_excl", 64'(bus_a.arr_wr_en), 64'd0);
                    if (first_rd_a < 0) first_rd_a = cyc;
                    q_a.push_back('{row: 2'(exp_row_a), data: mem_a[exp_row_a[1:0]], rd_cyc: cyc});
                    exp_row_a++;
                end
                if (bus_a.arr_wr_en) begin
                    if (q_a.size() == 0) begin
                        checkOutput("a_wr_unexpected", 64'd1, 64'd0);
                    end else begin
                        e = q_a.pop_front();
                        checkOutput("a_wr_row", 64'(bus_a.arr_row), 64'(e.row));
                        checkOutput("a_wr_data", 64'(bus_a.arr_wr_data), 64'(e.data));
                        checkOutput("a_wr_lat", 64'(cyc - e.rd_cyc), 64'(LAT_A + 1));
                        wr_a++;
                    end
                end
                if (bus_a.cycle_done) begin
                    done_a++;
                    checkOutput("a_pass_len", 64'(cyc - first_rd_a + 1), 64'(PASS_A));
                    checkOutput("a_rows_in_pass", 64'(exp_row_a), 64'(ROWS_A));
                    checkOutput("a_done_active", 64'(bus_a.refresh_active), 64'd1);
                    last_act_a = act_a;
                    act_a      = 0;
                    exp_row_a  = 0;
                    first_rd_a = -1;
                end
            end
        end
    end

    // Monitor B: same scoreboard for the long-latency, 3-row instance.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                q_b.delete();
                exp_row_b  = 0;
                first_rd_b = -1;
            end else begin
                if (bus_b.arr_rd_en) begin
                    checkOutput("b_rd_row", 64'(bus_b.arr_row), 64'(exp_row_b));
                    checkOutput("b_rd_wr_excl", 64'(bus_b.arr_wr_en), 64'd0);
                    if (first_rd_b < 0) first_rd_b = cyc;
                    q_b.push_back('{row: 2'(exp_row_b), data: mem_b[exp_row_b[1:0]], rd_cyc: cyc});
                    exp_row_b++;
                end
                if (bus_b.arr_wr_en) begin
                    if (q_b.size() == 0) begin
                        checkOutput("b_wr_unexpected", 64'd1, 64'd0);
                    end else begin
                        e = q_b.pop_front();
                        checkOutput("b_wr_row", 64'(bus_b.arr_row), 64'(e.row));
                        checkOutput("b_wr_data", 64'(bus_b.arr_wr_data), 64'(e.data));
                        checkOutput("b_wr_lat", 64'(cyc - e.rd_cyc), 64'(LAT_B + 1));
                        wr_b++;
                    end
                end
                if (bus_b.cycle_done) begin
                    done_b++;
                    checkOutput("b_pass_len", 64'(cyc - first_rd_b + 1), 64'(PASS_B));
                    checkOutput("b_rows_in_pass", 64'(exp_row_b), 64'(ROWS_B));
                    exp_row_b  = 0;
                    first_rd_b = -1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic req, input logic busy, input bit use_b);
        if (use_b) begin
            bus_b.refresh_req = req;
            bus_b.host_busy   = busy;
        end else begin
            bus_a.refresh_req = req;
            bus_a.host_busy   = busy;
        end
    endtask

    // Bounded wait for cycle_done; the counter drops its request on that edge
    // unless keep_req models a counter that has already re-armed.
    task automatic waitDone(input bit use_b, input bit keep_req, input int limit, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            tick();
            if (use_b ? bus_b.cycle_done : bus_a.cycle_done) begin
                seen = 1'b1;
                if (!keep_req) applyStimulus(1'b0, 1'b0, use_b);
            end
        end
        if (!seen) checkOutput({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int d0, w0, n;
        int done_times [$];
        int cnt;

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            mem_a[i] = 32'hA0 + 32'(i);
            mem_b[i] = 32'h5A5A_0001 + 32'(i);
        end
        repeat (3) tick();

        // Reset state.
        checkOutput("rst_active", 64'(bus_a.refresh_active), 64'd0);
        checkOutput("rst_rd_en", 64'(bus_a.arr_rd_en), 64'd0);
        checkOutput("rst_wr_en", 64'(bus_a.arr_wr_en), 64'd0);
        checkOutput("rst_done", 64'(bus_a.cycle_done), 64'd0);
        checkOutput("rst_row", 64'(bus_a.arr_row), 64'd0);
        checkOutput("rst_wr_data", 64'(bus_a.arr_wr_data), 64'd0);
        rst = 1'b0;
        repeat (2) tick();

        // Test 1: basic pass with idle host.
        $display("[TB] basic pass");
        d0 = done_a;
        w0 = wr_a;
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitDone(1'b0, 1'b0, 40, "t1");
        repeat (3) tick();
        checkOutput("t1_done_count", 64'(done_a - d0), 64'd1);
        checkOutput("t1_writes", 64'(wr_a - w0), 64'd4);
        checkOutput("t1_active_len", 64'(last_act_a), 64'(PASS_A));
        checkOutput("t1_idle_active", 64'(bus_a.refresh_active), 64'd0);
        checkOutput("t1_sb_empty", 64'(q_a.size()), 64'd0);

        // Test 2: host access in flight for 5 cycles when the request arrives.
        $display("[TB] host busy");
        for (int i = 0; i < 4; i++) mem_a[i] = 32'h1111_0000 + 32'(i * 7);
        d0 = done_a;
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("t2_active_rise", 64'(bus_a.refresh_active), 64'd1);
        checkOutput("t2_no_rd_first", 64'(bus_a.arr_rd_en), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("t2_no_rd_busy", 64'(bus_a.arr_rd_en), 64'd0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("t2_rd_after_busy", 64'(bus_a.arr_rd_en), 64'd1);
        checkOutput("t2_rd_row0", 64'(bus_a.arr_row), 64'd0);
        waitDone(1'b0, 1'b0, 40, "t2");
        repeat (2) tick();
        checkOutput("t2_active_len", 64'(last_act_a), 64'(PASS_A + 5));
        checkOutput("t2_done_count", 64'(done_a - d0), 64'd1);

        // Test 4: request still high after DONE gives one IDLE cycle, then a new pass.
        $display("[TB] back-to-back");
        d0 = done_a;
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitDone(1'b0, 1'b1, 40, "t4a");
        tick();
        checkOutput("t4_idle_gap", 64'(bus_a.refresh_active), 64'd0);
        checkOutput("t4_idle_no_rd", 64'(bus_a.arr_rd_en), 64'd0);
        tick();
        checkOutput("t4_restart_active", 64'(bus_a.refresh_active), 64'd1);
        checkOutput("t4_restart_rd", 64'(bus_a.arr_rd_en), 64'd1);
        checkOutput("t4_restart_row", 64'(bus_a.arr_row), 64'd0);
        waitDone(1'b0, 1'b0, 40, "t4b");
        repeat (2) tick();
        checkOutput("t4_done_count", 64'(done_a - d0), 64'd2);

        // Test 5: reset during the row 2 write-back.
        $display("[TB] reset mid-pass");
        applyStimulus(1'b1, 1'b0, 1'b0);
        n = 0;
        while (!(bus_a.arr_wr_en === 1'b1 && bus_a.arr_row === 2'd2) && n < 60) begin
            tick();
            n++;
        end
        checkOutput("t5_reached_row2", 64'(n < 60), 64'd1);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("t5_active", 64'(bus_a.refresh_active), 64'd0);
        checkOutput("t5_wr_en", 64'(bus_a.arr_wr_en), 64'd0);
        checkOutput("t5_rd_en", 64'(bus_a.arr_rd_en), 64'd0);
        checkOutput("t5_row", 64'(bus_a.arr_row), 64'd0);
        checkOutput("t5_wr_data", 64'(bus_a.arr_wr_data), 64'd0);
        checkOutput("t5_done", 64'(bus_a.cycle_done), 64'd0);
        repeat (2) tick();
        rst = 1'b0;
        d0 = done_a;
        repeat (20) tick();
        checkOutput("t5_no_done", 64'(done_a - d0), 64'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("t5_restart_row", 64'(bus_a.arr_row), 64'd0);
        checkOutput("t5_restart_rd", 64'(bus_a.arr_rd_en), 64'd1);
        waitDone(1'b0, 1'b0, 40, "t5");
        repeat (2) tick();
        checkOutput("t5_done_after", 64'(done_a - d0), 64'd1);

        // Test 3: READ_LAT=3, 3-row instance, two back-to-back passes to show the wrap.
        $display("[TB] long latency");
        d0 = done_b;
        w0 = wr_b;
        applyStimulus(1'b1, 1'b0, 1'b1);
        waitDone(1'b1, 1'b1, 60, "t3a");
        waitDone(1'b1, 1'b0, 60, "t3b");
        repeat (2) tick();
        checkOutput("t3_done_count", 64'(done_b - d0), 64'd2);
        checkOutput("t3_writes", 64'(wr_b - w0), 64'd6);
        checkOutput("t3_last_wr_data", 64'(bus_b.arr_wr_data), 64'h5A5A_0003);
        checkOutput("t3_idle_row", 64'(bus_b.arr_row), 64'd0);

        // Test 6: interval counter model, period 200, request cleared by cycle_done.
        $display("[TB] interval counter");
        d0  = done_a;
        cnt = 0;
        for (int c = 0; c < 650; c++) begin
            tick();
            if (bus_a.cycle_done) begin
                applyStimulus(1'b0, 1'b0, 1'b0);
                done_times.push_back(c);
            end
            cnt++;
            if (cnt == 200) begin
                cnt = 0;
                applyStimulus(1'b1, 1'b0, 1'b0);
            end
        end
        checkOutput("t6_passes", 64'(done_a - d0), 64'd3);
        checkOutput("t6_done_pulses", 64'(done_times.size()), 64'd3);
        if (done_times.size() == 3) begin
            checkOutput("t6_spacing1", 64'(done_times[1] - done_times[0]), 64'd200);
            checkOutput("t6_spacing2", 64'(done_times[2] - done_times[1]), 64'd200);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/refresh_sequencer.md
Name: refresh_sequencer

Overview:
- Consumes the periodic refresh request from the refresh-interval counter and performs one full refresh pass over the gain-cell array.
- For each row, it reads the row and writes the same data back.
- It asserts `refresh_active` so the host stalls, and returns a one-cycle `cycle_done` to clear the counter's request.
- It sits between the interval counter and the array access mux in the controller.

Parameters:
- NUM_ROWS, 32, number of array rows refreshed per pass (>=2).
- DATA_W, 32, array row data width.
- READ_LAT, 1, cycles from `arr_rd_en` to valid `arr_rd_data` (>=1).
- ROW_W, $clog2(NUM_ROWS), row address width (derived; not overridden).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- refresh_req  in  1  level request from the interval counter; held until `cycle_done`.
- host_busy  in  1  a host array access is still in flight.
- cycle_done  out  1  one-cycle pulse at end of pass; drives the counter's `cycle_done`.
- refresh_active  out  1  refresh owns the array; host must not start new accesses.
- arr_row  out  ROW_W  row address to the array while `refresh_active`.
- arr_rd_en  out  1  refresh read strobe.
- arr_wr_en  out  1  refresh write-back strobe.
- arr_wr_data  out  DATA_W  write-back data (captured read data).
- arr_rd_data  in  DATA_W  array read data.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, row_cnt=0, data_reg=0, wait_cnt=0.
  - All outputs 0; `arr_row`=0, `arr_wr_data`=0.
- States: IDLE, WAIT_HOST, READ, WAIT_DATA, WRITE, NEXT, DONE.
- IDLE:
  - refresh_req=1 and host_busy=1 -> WAIT_HOST.
  - refresh_req=1 and host_busy=0 -> READ.
  - refresh_req=0 -> stay in IDLE.
- WAIT_HOST: stay while host_busy=1; go to READ on the first cycle host_busy=0.
- READ: arr_rd_en=1 and arr_row=row_cnt for exactly one cycle -> WAIT_DATA, with wait_cnt=0.
- WAIT_DATA:
  - Lasts READ_LAT cycles.
  - `arr_rd_data` is sampled into data_reg at the edge ending the last WAIT_DATA cycle (data valid READ_LAT cycles after the rd_en cycle) -> WRITE.
- WRITE: arr_wr_en=1, arr_row=row_cnt, arr_wr_data=data_reg, for one cycle -> NEXT.
- NEXT:
  - row_cnt==NUM_ROWS-1 -> row_cnt<=0, go to DONE.
  - Otherwise row_cnt<=row_cnt+1, go to READ.
- DONE: cycle_done=1 for exactly one cycle -> IDLE.
  - The counter clears its request on that edge, so refresh_req is 0 in the following IDLE cycle.
  - If refresh_req is still 1 in IDLE, a new pass starts normally.
- refresh_active:
  - 1 in every state except IDLE, registered with the state.
  - Asserted from the first WAIT_HOST/READ cycle through the DONE cycle inclusive.
- Strobes: `arr_rd_en` and `arr_wr_en` are never high simultaneously, and never high outside READ/WRITE.
- arr_row: holds row_cnt in all non-IDLE states; 0 in IDLE.
- Pass length, from the first READ to the DONE cycle inclusive: NUM_ROWS*(READ_LAT+3)+1 cycles.
  - Integration rule: the counter's CYCLES must exceed this plus the maximum host_busy time.
  - The sequencer does not detect overrun.
- refresh_req deasserting mid-pass (counter reset only): the pass still completes and `cycle_done` is still pulsed.
- host_busy after leaving WAIT_HOST is ignored.
- Reset mid-pass: immediate return to IDLE with row_cnt=0; the next pass starts at row 0, and no `cycle_done` is issued for the aborted pass.
- Row counter never exceeds NUM_ROWS-1; non-power-of-2 NUM_ROWS wraps at NUM_ROWS-1, not at 2^ROW_W-1.

Decomposition:
- Shared package `gc_refresh_pkg`:
  - State enum typedef (refresh_state_t).
  - Localparam helpers for ROW_W and pass length (used by the bench and the counter sizing check).
- No sub-module. The row and wait counters are inline; the block is a single FSM with a small datapath.

Test Plan:
1. Basic pass, NUM_ROWS=4, READ_LAT=1: preload rows with 0xA0..0xA3, pulse refresh_req high with host_busy=0 -> rd/wr to rows 0..3 in order, each write data equals the row's read data, `cycle_done` high exactly once, 17 cycles after the first READ cycle (NUM_ROWS*(READ_LAT+3)+1=17, counted first READ to DONE inclusive), refresh_active high for exactly 17 cycles.
2. Host in flight: host_busy=1 for 5 cycles when refresh_req rises -> refresh_active rises next cycle, no `arr_rd_en` until the cycle after host_busy falls.
3. Latency: READ_LAT=3, row data 0x5A5A_0001 -> `arr_wr_data`=0x5A5A_0001, with `arr_wr_en` exactly 4 cycles after `arr_rd_en`.
4. Back-to-back: refresh_req held at 1 after DONE -> IDLE for one cycle, then a second pass starting again at row 0.
5. Reset mid-pass: assert rst at row 2 WRITE -> all outputs 0 asynchronously, no `cycle_done`, next request restarts at row 0.
6. Integration with the interval counter (CYCLES=200, NUM_ROWS=4): counter request cleared on `cycle_done`, three passes every 200 cycles, no missed or double passes.
